// File: rtl/rr_stream_arb_4_1_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arb_pkg
//  Description : Shared constants and types for the 4:1 round-robin stream
//                arbiter (port count, select width, select type).
//  Revision    : 1.0 - initial release
// ============================================================================
package rr_arb_pkg;

    localparam int N_PORTS = 4;
    localparam int SEL_W   = 2;

    typedef logic [SEL_W-1:0] sel_t;

endpackage : rr_arb_pkg
`default_nettype wire

// File: rtl/rr_stream_arb_4_1_if.sv
`default_nettype none
// ============================================================================
//  Module      : rr_stream_arb_4_1_if
//  Description : Four valid/ready input streams plus one registered
//                valid/ready output stream carrying data and source select.
//                "slave" is the arbiter view; "master" is the environment view.
//  Revision    : 1.0 - initial release
// ============================================================================
interface rr_stream_arb_4_1_if
    import rr_arb_pkg::*;
#(
    parameter int WIDTH = 4
);

    logic [N_PORTS-1:0] in_vld;
    logic [N_PORTS-1:0] in_rdy;
    logic [WIDTH-1:0]   d0;
    logic [WIDTH-1:0]   d1;
    logic [WIDTH-1:0]   d2;
    logic [WIDTH-1:0]   d3;
    logic               out_vld;
    logic               out_rdy;
    logic [WIDTH-1:0]   out_data;
    sel_t               out_sel;

    modport slave (
        input  in_vld, d0, d1, d2, d3, out_rdy,
        output in_rdy, out_vld, out_data, out_sel
    );

    modport master (
        output in_vld, d0, d1, d2, d3, out_rdy,
        input  in_rdy, out_vld, out_data, out_sel
    );

endinterface : rr_stream_arb_4_1_if
`default_nettype wire

// File: rtl/rr_stream_arb_4_1_mux.sv
`default_nettype none
// ============================================================================
//  Module      : mux_4_1_param
//  Description : Combinational 4:1 word mux, WIDTH bits per word.
//  Revision    : 1.0 - initial release
// ============================================================================
module mux_4_1_param
    import rr_arb_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] d0,
    input  logic [WIDTH-1:0] d1,
    input  logic [WIDTH-1:0] d2,
    input  logic [WIDTH-1:0] d3,
    input  sel_t             sel,
    output logic [WIDTH-1:0] y
);

    // Select one of the four words by index
    always_comb begin
        y = d0;
        case (sel)
            2'd0:    y = d0;
            2'd1:    y = d1;
            2'd2:    y = d2;
            default: y = d3;
        endcase
    end

endmodule : mux_4_1_param
`default_nettype wire

// File: rtl/rr_stream_arb_4_1.sv
`default_nettype none
// ============================================================================
//  Module      : rr_stream_arb_4_1
//  Description : Round-robin 4:1 valid/ready arbiter with a single registered
//                output stage. The winner's index travels with its data as
//                out_sel. One word per clock when downstream is ready.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_stream_arb_4_1
    import rr_arb_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    rr_stream_arb_4_1_if.slave   bus
);

    logic               w_load_en;
    logic               w_any_vld;
    logic               w_xfer;
    sel_t               w_gnt;
    logic [N_PORTS-1:0] w_in_rdy;
    logic [WIDTH-1:0]   w_mux_y;

    logic               r_out_vld_q,  w_out_vld_d;
    logic [WIDTH-1:0]   r_out_data_q, w_out_data_d;
    sel_t               r_out_sel_q,  w_out_sel_d;
    sel_t               r_ptr_q,      w_ptr_d;

    // The single output entry may be (re)loaded when empty or being drained
    assign w_load_en = !r_out_vld_q || bus.out_rdy;
    assign w_any_vld = |bus.in_vld;
    assign w_xfer    = w_load_en && w_any_vld && !rst;

    // Priority scan starting at ptr; descending offsets so the lowest offset wins
    always_comb begin
        sel_t v_idx;
        w_gnt = r_ptr_q;
        for (int k = N_PORTS - 1; k >= 0; k--) begin
            v_idx = r_ptr_q + sel_t'(k);
            if (bus.in_vld[v_idx]) begin
                w_gnt = v_idx;
            end
        end
    end

    // One-hot ready at the granted port; depends only on valids, state and out_rdy
    always_comb begin
        w_in_rdy = '0;
        if (w_xfer) begin
            w_in_rdy[w_gnt] = 1'b1;
        end
    end

    assign bus.in_rdy = w_in_rdy;

    mux_4_1_param #(
        .WIDTH (WIDTH)
    ) u_mux (
        .d0  (bus.d0),
        .d1  (bus.d1),
        .d2  (bus.d2),
        .d3  (bus.d3),
        .sel (w_gnt),
        .y   (w_mux_y)
    );

    // Next state of the output register and the round-robin pointer
    always_comb begin
        w_out_vld_d  = r_out_vld_q;
        w_out_data_d = r_out_data_q;
        w_out_sel_d  = r_out_sel_q;
        w_ptr_d      = r_ptr_q;
        if (w_xfer) begin
            w_out_vld_d  = 1'b1;
            w_out_data_d = w_mux_y;
            w_out_sel_d  = w_gnt;
            w_ptr_d      = w_gnt + sel_t'(1);
        end else if (w_load_en) begin
            w_out_vld_d  = 1'b0;
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_vld_q  <= 1'b0;
            r_out_data_q <= '0;
            r_out_sel_q  <= '0;
            r_ptr_q      <= '0;
        end else begin
            r_out_vld_q  <= w_out_vld_d;
            r_out_data_q <= w_out_data_d;
            r_out_sel_q  <= w_out_sel_d;
            r_ptr_q      <= w_ptr_d;
        end
    end

    assign bus.out_vld  = r_out_vld_q;
    assign bus.out_data = r_out_data_q;
    assign bus.out_sel  = r_out_sel_q;

endmodule : rr_stream_arb_4_1
`default_nettype wire

// File: tb/tb_rr_stream_arb_4_1.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rr_stream_arb_4_1
//  Description : Self-checking bench for rr_stream_arb_4_1. Directed vector
//                table with per-cycle expected outputs, a reference grant
//                model, and a scoreboard of accepted words.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rr_stream_arb_4_1;

    logic clk;
    logic rst;

    rr_stream_arb_4_1_if #(.WIDTH(4)) bus ();

    rr_stream_arb_4_1 #(
        .WIDTH (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic       rst;
        logic [3:0] vld;
        logic [15:0] d;      // {d3,d2,d1,d0}
        logic       ordy;
        logic [3:0] erdy;
        logic       evld;
        logic [1:0] esel;
        logic [3:0] edata;
    } vec_t;

    typedef struct packed {
        logic [3:0] data;
        logic [1:0] sel;
    } sb_t;

    vec_t tbl[$];
    sb_t  sbq[$];

    int   n_cmp = 0;
    int   n_err = 0;

    int   m_ptr = 0;
    logic m_vld = 1'b0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic void add(input string nm, input logic r, input logic [3:0] vld,
                                input logic [15:0] d, input logic ordy, input logic [3:0] erdy,
                                input logic evld, input logic [1:0] esel, input logic [3:0] edata);
        vec_t v;
        v.name = nm; v.rst = r; v.vld = vld; v.d = d; v.ordy = ordy;
        v.erdy = erdy; v.evld = evld; v.esel = esel; v.edata = edata;
        tbl.push_back(v);
    endfunction

    function automatic int model_grant(input logic [3:0] vld, input int ptr);
        int g;
        bit found;
        g = 0;
        found = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (!found && vld[(ptr + k) % 4]) begin
                g = (ptr + k) % 4;
                found = 1'b1;
            end
        end
        return g;
    endfunction

    // Drive one cycle, check in_rdy against the model, run the scoreboard
    task automatic drive_step(input string nm, input logic r, input logic [3:0] vld,
                              input logic [15:0] d, input logic ordy);
        logic [3:0] exp_rdy;
        int         g;
        sb_t        e;
        @(negedge clk);
        rst         = r;
        bus.in_vld  = vld;
        bus.d0      = d[3:0];
        bus.d1      = d[7:4];
        bus.d2      = d[11:8];
        bus.d3      = d[15:12];
        bus.out_rdy = ordy;
        #1;
        exp_rdy = 4'b0000;
        g = model_grant(vld, m_ptr);
        if (!r && (!m_vld || ordy) && (vld != 4'b0000)) exp_rdy[g] = 1'b1;
        check({nm, "/model_in_rdy"}, {28'b0, bus.in_rdy}, {28'b0, exp_rdy});
        check({nm, "/model_out_vld"}, {31'b0, bus.out_vld}, {31'b0, m_vld});
        if (bus.out_vld === 1'b1 && ordy) begin
            if (sbq.size() == 0) begin
                check({nm, "/sb_underflow"}, 32'd1, 32'd0);
            end else begin
                e = sbq.pop_front();
                check({nm, "/sb_data"}, {28'b0, bus.out_data}, {28'b0, e.data});
                check({nm, "/sb_sel"},  {30'b0, bus.out_sel},  {30'b0, e.sel});
            end
        end
        if (r) begin
            sbq.delete();
            m_vld = 1'b0;
            m_ptr = 0;
        end else if (!m_vld || ordy) begin
            if (vld != 4'b0000) begin
                e.data = d[g*4 +: 4];
                e.sel  = 2'(g);
                sbq.push_back(e);
                m_vld = 1'b1;
                m_ptr = (g + 1) % 4;
            end else begin
                m_vld = 1'b0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run_vec(input vec_t v);
        drive_step(v.name, v.rst, v.vld, v.d, v.ordy);
        // in_rdy settled before the edge; recheck the table value now against the
        // pre-edge snapshot was done by the model, so here only registered outputs
        check({v.name, "/out_vld"},  {31'b0, bus.out_vld},  {31'b0, v.evld});
        check({v.name, "/out_sel"},  {30'b0, bus.out_sel},  {30'b0, v.esel});
        check({v.name, "/out_data"}, {28'b0, bus.out_data}, {28'b0, v.edata});
    endtask

    // Directed table also states in_rdy; checked just before each edge
    logic [3:0] tbl_rdy_q[$];
    string      tbl_nm_q[$];

    initial begin
        rst         = 1'b1;
        bus.in_vld  = 4'hF;
        bus.d0      = '0;
        bus.d1      = '0;
        bus.d2      = '0;
        bus.d3      = '0;
        bus.out_rdy = 1'b1;
        @(posedge clk);
        #1;

        // Reset
        add("rst0",  1, 4'hF, 16'hDCBA, 1, 4'b0000, 0, 2'd0, 4'h0);
        add("rst1",  1, 4'hF, 16'hDCBA, 1, 4'b0000, 0, 2'd0, 4'h0);
        // Round-robin over all four ports, pointer wraps
        add("rr0",   0, 4'hF, 16'hDCBA, 1, 4'b0001, 1, 2'd0, 4'hA);
        add("rr1",   0, 4'hF, 16'hDCBA, 1, 4'b0010, 1, 2'd1, 4'hB);
        add("rr2",   0, 4'hF, 16'hDCBA, 1, 4'b0100, 1, 2'd2, 4'hC);
        add("rr3",   0, 4'hF, 16'hDCBA, 1, 4'b1000, 1, 2'd3, 4'hD);
        add("rr4",   0, 4'hF, 16'hDCBA, 1, 4'b0001, 1, 2'd0, 4'hA);
        // Skip idle ports
        add("skip0", 0, 4'hA, 16'hDCBA, 1, 4'b0010, 1, 2'd1, 4'hB);
        add("skip1", 0, 4'hA, 16'hDCBA, 1, 4'b1000, 1, 2'd3, 4'hD);
        add("skip2", 0, 4'hA, 16'hDCBA, 1, 4'b0010, 1, 2'd1, 4'hB);
        add("skip3", 0, 4'hA, 16'hDCBA, 1, 4'b1000, 1, 2'd3, 4'hD);
        // Stall with a held word, then drain and refill in one clock
        add("fill",  0, 4'h4, 16'h3721, 1, 4'b0100, 1, 2'd2, 4'h7);
        add("stl0",  0, 4'hF, 16'h3721, 0, 4'b0000, 1, 2'd2, 4'h7);
        add("stl1",  0, 4'hF, 16'h3721, 0, 4'b0000, 1, 2'd2, 4'h7);
        add("stl2",  0, 4'hF, 16'h3721, 0, 4'b0000, 1, 2'd2, 4'h7);
        add("refil", 0, 4'hF, 16'h3721, 1, 4'b1000, 1, 2'd3, 4'h3);
        // Single active port, back-to-back
        add("one0",  0, 4'h8, 16'h5000, 1, 4'b1000, 1, 2'd3, 4'h5);
        add("one1",  0, 4'h8, 16'h6000, 1, 4'b1000, 1, 2'd3, 4'h6);
        add("one2",  0, 4'h8, 16'h7000, 1, 4'b1000, 1, 2'd3, 4'h7);
        // Mid-operation reset discards the held word
        add("mrst",  1, 4'hF, 16'hDCBA, 0, 4'b0000, 0, 2'd0, 4'h0);
        add("post",  0, 4'hF, 16'hDCBA, 1, 4'b0001, 1, 2'd0, 4'hA);
        // Idle: valid drops, data/sel hold
        add("idle0", 0, 4'h0, 16'hDCBA, 1, 4'b0000, 0, 2'd0, 4'hA);
        add("idle1", 0, 4'h0, 16'hDCBA, 0, 4'b0000, 0, 2'd0, 4'hA);
        // Empty stage loads even with out_rdy low
        add("ld_nr", 0, 4'h2, 16'h0090, 0, 4'b0010, 1, 2'd1, 4'h9);
        add("drain", 0, 4'h0, 16'h0090, 1, 4'b0000, 0, 2'd1, 4'h9);

        foreach (tbl[i]) begin
            fork
                begin
                    // Pre-edge in_rdy against the hand-computed table value
                    @(negedge clk);
                    #2;
                    check({tbl[i].name, "/in_rdy"}, {28'b0, bus.in_rdy}, {28'b0, tbl[i].erdy});
                end
                run_vec(tbl[i]);
            join
        end

        // Random traffic: only model and scoreboard checks
        for (int n = 0; n < 400; n++) begin
            drive_step("rand", ($urandom_range(0, 59) == 0),
                       4'($urandom_range(0, 15)), 16'($urandom),
                       ($urandom_range(0, 3) != 0));
        end
        drive_step("flush", 1'b0, 4'h0, 16'h0, 1'b1);
        drive_step("flush", 1'b0, 4'h0, 16'h0, 1'b1);
        check("sb_empty", 32'(sbq.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_rr_stream_arb_4_1
`default_nettype wire
